prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/loader_pkg.sv | 23 ++
 rtl/prog_loader_if.sv | 25 ++
 rtl/byte_packer.sv | 73 +++++++
 rtl/prog_loader.sv | 162 ++++++++++++++++
 tb/tb_prog_loader.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader.
//   state_e        : loader FSM states
//   HDR_BYTES      : length of the word-count header in bytes
//   BYTES_PER_WORD : bytes packed into one instruction word
//   word_addr()    : byte address of instruction word idx relative to a base
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  function automatic logic [63:0] word_addr(input logic [63:0] base, input logic [15:0] idx);
    return base + {46'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in / instruction-memory write out, bundled for the loader.
//   rx_valid, rx_data : byte offered by the host
//   rx_ready          : loader takes the byte this cycle
//   im_wr_en          : one-cycle instruction-memory write strobe
//   im_wr_addr        : byte address of the write
//   im_wr_data        : instruction word written
// master = host / memory side, slave = loader side.
interface prog_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        im_wr_en;
  logic [63:0] im_wr_addr;
  logic [31:0] im_wr_data;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, im_wr_en, im_wr_addr, im_wr_data
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, im_wr_en, im_wr_addr, im_wr_data
  );
endinterface

// File: rtl/byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : restart packing at byte 0 (partial word dropped)
//   i_accept       : i_byte is consumed this cycle
//   i_byte         : byte value
//   o_last         : this accept completes a word (combinational)
//   o_word_vld     : one-cycle pulse, the cycle after a word completes
//   o_word         : last completed word, held until the next one
module byte_packer
  import loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic        o_last,
  output logic        o_word_vld,
  output logic [31:0] o_word
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  r_cnt;
  logic        r_word_vld;
  logic [31:0] r_word;

  assign o_last = i_accept && (r_cnt == LAST_IDX);

  // Counter wraps naturally from 3 back to 0 at the end of each word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_accept) begin
      r_cnt <= r_cnt + 2'd1;
    end
  end

  // Byte lanes 0..2 are held; lane 3 comes straight from the completing byte.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
      logic [7:0] r_lane;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_lane <= '0;
        end else if (i_clr) begin
          r_lane <= '0;
        end else if (i_accept && (r_cnt == 2'(gi))) begin
          r_lane <= i_byte;
        end
      end
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word_vld <= 1'b0;
      r_word     <= '0;
    end else begin
      r_word_vld <= o_last && !i_clr;
      if (o_last && !i_clr) begin
        r_word <= {i_byte, g_lane[2].r_lane, g_lane[1].r_lane, g_lane[0].r_lane};
      end
    end
  end

  assign o_word_vld = r_word_vld;
  assign o_word     = r_word;

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: receives a 16-bit little-endian word count and
// that many 32-bit little-endian words over a byte stream, writes them to
// instruction memory from BASE_ADDR upward, then releases the core.
//   CLK        : clock
//   RST        : asynchronous active-low reset (deassertion synchronised)
//   bus        : byte stream in, instruction-memory writes out
//   load_req   : one-cycle pulse starting a load (from IDLE, DONE or ERR)
//   core_rst_n : core reset, released only in DONE
//   busy       : header or payload being received
//   done       : load completed
//   err        : header word count exceeded MAX_WORDS
module prog_loader
  import loader_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'd0,
  parameter int          MAX_WORDS = 256
) (
  input  logic         CLK,
  input  logic         RST,
  prog_loader_if.slave bus,
  input  logic         load_req,
  output logic         core_rst_n,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  logic [1:0]  r_rst_sync;
  logic        w_rst_n;
  state_e      r_state;
  state_e      w_state_next;
  logic        r_hdr_cnt;
  logic [7:0]  r_hdr_lo;
  logic [15:0] r_n_words;
  logic [15:0] r_word_idx;
  logic [63:0] r_wr_addr;
  logic        w_rx_ready;
  logic        w_accept;
  logic        w_hdr_last;
  logic [15:0] w_hdr_n;
  logic        w_start;
  logic        w_pk_accept;
  logic        w_pk_last;
  logic        w_pk_vld;
  logic [31:0] w_pk_word;

  // Assertion is immediate; release reaches the logic two edges later.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_rx_ready  = (r_state == ST_HDR) || (r_state == ST_LOAD);
  assign w_accept    = bus.rx_valid && w_rx_ready;
  assign w_hdr_n     = {bus.rx_data, r_hdr_lo};
  assign w_hdr_last  = (r_state == ST_HDR) && w_accept && (r_hdr_cnt == 1'(HDR_BYTES - 1));
  assign w_pk_accept = (r_state == ST_LOAD) && w_accept;

  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    core_rst_n   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (load_req) begin
          w_state_next = ST_HDR;
          w_start      = 1'b1;
        end
      end
      ST_HDR: begin
        busy = 1'b1;
        if (w_hdr_last) begin
          if (w_hdr_n == 16'd0)             w_state_next = ST_DONE;
          else if ({1'b0, w_hdr_n} > MAX_N) w_state_next = ST_ERR;
          else                              w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy = 1'b1;
        // Leaving on the last byte makes DONE coincide with the final write.
        if (w_pk_last && (r_word_idx == r_n_words - 16'd1)) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        core_rst_n = 1'b1;
        if (load_req) begin
          w_state_next = ST_HDR;
          w_start      = 1'b1;
        end
      end
      ST_ERR: begin
        err = 1'b1;
        if (load_req) begin
          w_state_next = ST_HDR;
          w_start      = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_hdr_cnt  <= 1'b0;
      r_hdr_lo   <= '0;
      r_n_words  <= '0;
      r_word_idx <= '0;
      r_wr_addr  <= BASE_ADDR;
    end else begin
      if (w_start) begin
        r_hdr_cnt  <= 1'b0;
        r_word_idx <= '0;
      end else if ((r_state == ST_HDR) && w_accept) begin
        r_hdr_cnt <= r_hdr_cnt + 1'b1;
        if (r_hdr_cnt == 1'b0) r_hdr_lo <= bus.rx_data;
        if (w_hdr_last)        r_n_words <= w_hdr_n;
      end
      // Address is registered alongside the packer's word so both appear
      // together on the write pulse.
      if (w_pk_last) begin
        r_wr_addr  <= word_addr(BASE_ADDR, r_word_idx);
        r_word_idx <= r_word_idx + 16'd1;
      end
    end
  end

  byte_packer u_packer (
    .i_clk      (CLK),
    .i_rst_n    (w_rst_n),
    .i_clr      (w_start),
    .i_accept   (w_pk_accept),
    .i_byte     (bus.rx_data),
    .o_last     (w_pk_last),
    .o_word_vld (w_pk_vld),
    .o_word     (w_pk_word)
  );

  assign bus.rx_ready   = w_rx_ready;
  assign bus.im_wr_en   = w_pk_vld;
  assign bus.im_wr_addr = r_wr_addr;
  assign bus.im_wr_data = w_pk_word;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed scenarios plus random loads,
// checked against a reference built from the byte-stream format.
module tb_prog_loader;

  localparam logic [63:0] BASE = 64'd0;
  localparam int          MAXW = 256;

  logic CLK = 1'b0;
  logic RST;
  logic load_req;
  logic core_rst_n, busy, done, err;

  prog_loader_if bus ();

  prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .bus        (bus),
    .load_req   (load_req),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Observed instruction-memory writes
  logic [63:0] mon_addr[$];
  logic [31:0] mon_data[$];
  int          mon_cyc[$];

  always @(negedge CLK) begin
    if (bus.im_wr_en === 1'b1) begin
      mon_addr.push_back(bus.im_wr_addr);
      mon_data.push_back(bus.im_wr_data);
      mon_cyc.push_back(cyc);
    end
  end

  logic [7:0] pl[$];   // payload bytes of the next load

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    mon_addr.delete();
    mon_data.delete();
    mon_cyc.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rx_ready"},   64'(bus.rx_ready),  64'd0);
    chk({tag, "_wr_en"},      64'(bus.im_wr_en),  64'd0);
    chk({tag, "_wr_addr"},    bus.im_wr_addr,     BASE);
    chk({tag, "_wr_data"},    64'(bus.im_wr_data), 64'd0);
    chk({tag, "_core_rst_n"}, 64'(core_rst_n),    64'd0);
    chk({tag, "_busy"},       64'(busy),          64'd0);
    chk({tag, "_done"},       64'(done),          64'd0);
    chk({tag, "_err"},        64'(err),           64'd0);
  endtask

  task automatic fill_random(input int nwords);
    pl.delete();
    for (int i = 0; i < 4 * nwords; i++) pl.push_back(8'($urandom));
  endtask

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    if (gaps && ($urandom_range(0, 3) == 0)) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      load_req     = 1'($urandom_range(0, 1));   // must be ignored mid-load
      repeat ($urandom_range(1, 3)) @(negedge CLK);
      load_req = 1'b0;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while ((bus.rx_ready !== 1'b1) && (n < 20)) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 20) chk("rx_ready_timeout", 64'(bus.rx_ready), 64'd1);
    @(negedge CLK);
  endtask

  // load_req pulse with a stray byte offered in the same cycle.
  task automatic pulse_load();
    @(negedge CLK);
    load_req     = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hEE;
    @(negedge CLK);
    load_req     = 1'b0;
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] n, input bit gaps, input string name);
    int  nn;
    int  nw;
    bit  ok_load;
    logic [31:0] w;
    nn      = int'(n);
    ok_load = (nn >= 1) && (nn <= MAXW);
    nw      = ok_load ? nn : 0;
    mon_clear();
    pulse_load();
    chk({name, "_start_busy"}, 64'(busy), 64'd1);
    chk({name, "_start_done"}, 64'(done), 64'd0);
    chk({name, "_start_err"},  64'(err),  64'd0);
    send_byte(n[7:0], gaps);
    send_byte(n[15:8], gaps);
    if (ok_load) begin
      foreach (pl[i]) send_byte(pl[i], gaps);
    end
    bus.rx_valid = 1'b0;
    // One cycle after the final byte the outcome must already be visible.
    chk({name, "_end_done"},       64'(done),          64'(nn <= MAXW));
    chk({name, "_end_err"},        64'(err),           64'(nn > MAXW));
    chk({name, "_end_core_rst_n"}, 64'(core_rst_n),    64'(nn <= MAXW));
    chk({name, "_end_busy"},       64'(busy),          64'd0);
    chk({name, "_end_rx_ready"},   64'(bus.rx_ready),  64'd0);
    chk({name, "_end_wr_en"},      64'(bus.im_wr_en),  64'(ok_load));
    repeat (3) @(negedge CLK);
    #1;
    chk({name, "_n_writes"}, 64'(mon_addr.size()), 64'(nw));
    for (int k = 0; (k < nw) && (k < mon_addr.size()); k++) begin
      w = {pl[4*k+3], pl[4*k+2], pl[4*k+1], pl[4*k]};
      chk($sformatf("%s_addr%0d", name, k), mon_addr[k], BASE + 64'(k) * 64'd4);
      chk($sformatf("%s_data%0d", name, k), 64'(mon_data[k]), 64'(w));
      if (!gaps && (k > 0))
        chk($sformatf("%s_gap%0d", name, k), 64'(mon_cyc[k] - mon_cyc[k-1]), 64'd4);
    end
    $display("load %s: N=%0d writes=%0d done=%0b err=%0b core_rst_n=%0b",
             name, nn, mon_addr.size(), done, err, core_rst_n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rn;
    int          r;
    RST          = 1'b1;
    load_req     = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    #1 RST = 1'b0;
    #2 chk_reset("por");
    repeat (3) @(negedge CLK);
    chk_reset("por_hold");

    // Release reset with load_req held across the two synchroniser edges.
    RST      = 1'b1;
    load_req = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    load_req = 1'b0;
    #1 chk("sync_hold_busy", 64'(busy), 64'd0);
    @(negedge CLK);
    $display("reset released, loader idle");

    // Two-word program from the example stream.
    pl = {8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    do_load(16'd2, 1'b0, "example");
    if (mon_data.size() == 2) begin
      chk("example_word0", 64'(mon_data[0]), 64'h0050_0013);
      chk("example_word1", 64'(mon_data[1]), 64'h00A0_0093);
      chk("example_addr1", mon_addr[1], 64'd4);
    end

    do_load(16'd0, 1'b0, "empty");
    do_load(16'd257, 1'b0, "oversize");

    // Bytes offered in ERR must be left alone.
    mon_clear();
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h5A;
    repeat (6) @(negedge CLK);
    bus.rx_valid = 1'b0;
    #1;
    chk("err_hold_err", 64'(err), 64'd1);
    chk("err_hold_writes", 64'(mon_addr.size()), 64'd0);

    // Reset pulsed after 6 of 8 payload bytes.
    fill_random(2);
    mon_clear();
    pulse_load();
    send_byte(8'd2, 1'b0);
    send_byte(8'd0, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(pl[i], 1'b0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = pl[6];
    #1;
    chk("abort_pre_writes", 64'(mon_addr.size()), 64'd1);
    chk("abort_pre_data", 64'(bus.im_wr_data), 64'({pl[3], pl[2], pl[1], pl[0]}));
    #1 RST = 1'b0;
    #1 chk_reset("abort_rst");
    @(negedge CLK);
    RST = 1'b1;
    repeat (6) @(negedge CLK);
    bus.rx_valid = 1'b0;
    #1;
    chk("abort_post_writes", 64'(mon_addr.size()), 64'd1);
    chk("abort_post_busy", 64'(busy), 64'd0);
    $display("load abort: reset after 6 payload bytes, writes=%0d", mon_addr.size());
    fill_random(1);
    do_load(16'd1, 1'b1, "restart");

    // Streaming load, then reload straight from DONE.
    fill_random(4);
    do_load(16'd4, 1'b0, "stream4");
    fill_random(3);
    do_load(16'd3, 1'b1, "reload3");

    // Capacity boundary.
    fill_random(MAXW);
    do_load(16'(MAXW), 1'b0, "nmax");

    // Random loads.
    for (int t = 0; t < 8; t++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      rn = 16'd0;
      else if (r == 1) rn = 16'($urandom_range(MAXW + 1, 65535));
      else             rn = 16'($urandom_range(1, 10));
      if ((rn != 0) && (int'(rn) <= MAXW)) fill_random(int'(rn));
      do_load(rn, 1'($urandom_range(0, 1)), $sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
